// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage ARM PPU: EX/MEM/WB tag shadow,
// load-use stall / branch flush FSM, operand forwarding selects. Optional stats: HAZARD_STATS_EN.
module hazard_forward_ctrl #(
  parameter int LOAD_USE_STALLS = 1,
  parameter int REG_AW          = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rn,
  input  logic [REG_AW-1:0] id_rm,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_rn,
  input  logic              id_use_rm,
  input  logic              id_use_rd,
  input  logic              id_rf_en,
  input  logic              id_load,
  input  logic              id_branch_taken,
  output logic              le_out,
  output logic              nop_sel,
  output logic              ifid_flush,
  output logic [1:0]        fwd_rn,
  output logic [1:0]        fwd_rm,
  output logic [1:0]        fwd_rd,
  output logic              stall_active
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]       stall_count,
  output logic [15:0]       flush_count
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [REG_AW-1:0] PC_ADDR = {REG_AW{1'b1}};

  state_t            state;
  logic [1:0]        cnt;
  logic [REG_AW-1:0] ex_rd;
  logic [REG_AW-1:0] mem_rd;
  logic [REG_AW-1:0] wb_rd;
  logic              ex_wr;
  logic              mem_wr;
  logic              wb_wr;
  logic              ex_ld;
  logic              load_use;

  // Youngest in-flight producer wins; R15 is the PC and is never bypassed.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] addr,
    input logic              used,
    input logic [REG_AW-1:0] e_rd,
    input logic              e_v,
    input logic [REG_AW-1:0] m_rd,
    input logic              m_v,
    input logic [REG_AW-1:0] w_rd,
    input logic              w_v
  );
    logic [1:0] sel;
    if (!used || addr == PC_ADDR) begin
      sel = 2'b00;
    end else if (e_v && e_rd == addr) begin
      sel = 2'b01;
    end else if (m_v && m_rd == addr) begin
      sel = 2'b10;
    end else if (w_v && w_rd == addr) begin
      sel = 2'b11;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  function automatic logic ex_hit(input logic [REG_AW-1:0] addr, input logic used,
                                  input logic [REG_AW-1:0] e_rd);
    return used && (addr != PC_ADDR) && (addr == e_rd);
  endfunction

  // Load in EX whose result is needed by the instruction in ID.
  always_comb begin
    load_use = ex_wr && ex_ld &&
               (ex_hit(id_rn, id_use_rn, ex_rd) ||
                ex_hit(id_rm, id_use_rm, ex_rd) ||
                ex_hit(id_rd, id_use_rd, ex_rd));
  end

  // Same-cycle pipeline control; reset forces the idle values.
  always_comb begin
    le_out     = 1'b1;
    nop_sel    = 1'b0;
    ifid_flush = 1'b0;
    if (reset) begin
      le_out = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (load_use) begin
            le_out  = 1'b0;
            nop_sel = 1'b1;
          end else if (id_branch_taken) begin
            ifid_flush = 1'b1;
          end else begin
            ifid_flush = 1'b0;
          end
        end
        STALL: begin
          le_out  = 1'b0;
          nop_sel = 1'b1;
        end
        FLUSH:   le_out = 1'b1;
        default: le_out = 1'b1;
      endcase
    end
  end

  // Operand bypass selects and state flag.
  always_comb begin
    fwd_rn       = 2'b00;
    fwd_rm       = 2'b00;
    fwd_rd       = 2'b00;
    stall_active = 1'b0;
    if (reset) begin
      stall_active = 1'b0;
    end else begin
      fwd_rn       = fwd_sel(id_rn, id_use_rn, ex_rd, ex_wr, mem_rd, mem_wr, wb_rd, wb_wr);
      fwd_rm       = fwd_sel(id_rm, id_use_rm, ex_rd, ex_wr, mem_rd, mem_wr, wb_rd, wb_wr);
      fwd_rd       = fwd_sel(id_rd, id_use_rd, ex_rd, ex_wr, mem_rd, mem_wr, wb_rd, wb_wr);
      stall_active = (state == STALL);
    end
  end

  // Destination tag shadow; a bubble enters EX as an invalid tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rd  <= {REG_AW{1'b0}};
      mem_rd <= {REG_AW{1'b0}};
      wb_rd  <= {REG_AW{1'b0}};
      ex_wr  <= 1'b0;
      mem_wr <= 1'b0;
      wb_wr  <= 1'b0;
      ex_ld  <= 1'b0;
    end else begin
      ex_rd  <= id_rd;
      ex_wr  <= id_rf_en & ~nop_sel;
      ex_ld  <= id_load & ~nop_sel;
      mem_rd <= ex_rd;
      mem_wr <= ex_wr;
      wb_rd  <= mem_rd;
      wb_wr  <= mem_wr;
    end
  end

  // Stall/flush sequencing; cnt holds the STALL cycles still to run.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (load_use) begin
            cnt   <= 2'(LOAD_USE_STALLS - 1);
            state <= (LOAD_USE_STALLS > 1) ? STALL : RUN;
          end else if (id_branch_taken) begin
            state <= FLUSH;
          end else begin
            state <= RUN;
          end
        end
        STALL: begin
          if (cnt <= 2'd1) begin
            cnt   <= 2'd0;
            state <= RUN;
          end else begin
            cnt   <= cnt - 2'd1;
          end
        end
        FLUSH:   state <= RUN;
        default: begin
          state <= RUN;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating bubble and flush event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      if (nop_sel && stall_count != 16'hFFFF) begin
        stall_count <= stall_count + 16'd1;
      end
      if (ifid_flush && flush_count != 16'hFFFF) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: directed scenarios plus randomized traffic
// against an in-flight-instruction model, on two instances (1 and 3 load-use bubbles).
module tb_hazard_forward_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] id_rn, id_rm, id_rd;
  logic       id_use_rn, id_use_rm, id_use_rd, id_rf_en, id_load, id_branch_taken;

  logic       le1, nop1, fl1, sa1, le3, nop3, fl3, sa3;
  logic [1:0] frn1, frm1, frd1, frn3, frm3, frd3;
`ifdef HAZARD_STATS_EN
  logic [15:0] sc1, fc1, sc3, fc3;
`endif

  // observed bundle: {le, nop, flush, stall_active, fwd_rn, fwd_rm, fwd_rd}
  logic [9:0] obs1, obs3;
  assign obs1 = {le1, nop1, fl1, sa1, frn1, frm1, frd1};
  assign obs3 = {le3, nop3, fl3, sa3, frn3, frm3, frd3};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.LOAD_USE_STALLS(1), .REG_AW(4)) dut1 (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
    .id_rf_en(id_rf_en), .id_load(id_load), .id_branch_taken(id_branch_taken),
    .le_out(le1), .nop_sel(nop1), .ifid_flush(fl1),
    .fwd_rn(frn1), .fwd_rm(frm1), .fwd_rd(frd1), .stall_active(sa1)
`ifdef HAZARD_STATS_EN
    , .stall_count(sc1), .flush_count(fc1)
`endif
  );

  hazard_forward_ctrl #(.LOAD_USE_STALLS(3), .REG_AW(4)) dut3 (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
    .id_rf_en(id_rf_en), .id_load(id_load), .id_branch_taken(id_branch_taken),
    .le_out(le3), .nop_sel(nop3), .ifid_flush(fl3),
    .fwd_rn(frn3), .fwd_rm(frm3), .fwd_rd(frd3), .stall_active(sa3)
`ifdef HAZARD_STATS_EN
    , .stall_count(sc3), .flush_count(fc3)
`endif
  );

  // ---------------- reference model: list of instructions in EX/MEM/WB ----------------
  typedef struct packed {
    logic [3:0] rd;
    logic       wr;
    logic       ld;
  } tag_t;

  tag_t       mp [2][3];
  int         bubbles_left [2];
  bit         in_flush [2];
  int         nstall [2] = '{1, 3};
  logic [9:0] exp_b [2];
  bit         e_lu [2];
  bit         e_nop [2];

  function automatic logic [1:0] m_fwd(int k, logic [3:0] a, logic u);
    for (int s = 0; s < 3; s++) begin
      if (u && a != 4'hF && mp[k][s].wr && mp[k][s].rd == a) return 2'(s + 1);
    end
    return 2'b00;
  endfunction

  function automatic bit m_needs(int k, logic [3:0] a, logic u);
    return u && a != 4'hF && a == mp[k][0].rd;
  endfunction

  task automatic m_eval(int k);
    logic le, nop, fl;
    e_lu[k] = mp[k][0].wr && mp[k][0].ld &&
              (m_needs(k, id_rn, id_use_rn) || m_needs(k, id_rm, id_use_rm) ||
               m_needs(k, id_rd, id_use_rd));
    le = 1'b1; nop = 1'b0; fl = 1'b0;
    if (reset) begin
      exp_b[k] = 10'b1000_00_00_00;
    end else begin
      if (bubbles_left[k] > 0) begin
        le = 1'b0; nop = 1'b1;
      end else if (in_flush[k]) begin
        le = 1'b1;
      end else if (e_lu[k]) begin
        le = 1'b0; nop = 1'b1;
      end else if (id_branch_taken) begin
        fl = 1'b1;
      end
      exp_b[k] = {le, nop, fl, (bubbles_left[k] > 0),
                  m_fwd(k, id_rn, id_use_rn), m_fwd(k, id_rm, id_use_rm), m_fwd(k, id_rd, id_use_rd)};
    end
    e_nop[k] = nop;
  endtask

  task automatic m_step(int k);
    if (reset) begin
      for (int s = 0; s < 3; s++) mp[k][s] = '0;
      bubbles_left[k] = 0;
      in_flush[k]     = 1'b0;
    end else begin
      mp[k][2] = mp[k][1];
      mp[k][1] = mp[k][0];
      mp[k][0] = '{rd: id_rd, wr: id_rf_en & ~e_nop[k], ld: id_load & ~e_nop[k]};
      if (bubbles_left[k] > 0) bubbles_left[k]--;
      else if (in_flush[k]) in_flush[k] = 1'b0;
      else if (e_lu[k]) bubbles_left[k] = nstall[k] - 1;
      else if (id_branch_taken) in_flush[k] = 1'b1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                       input logic urn, input logic urm, input logic urd,
                       input logic rf, input logic ld, input logic br);
    @(negedge clk);
    id_rn = rn; id_rm = rm; id_rd = rd;
    id_use_rn = urn; id_use_rm = urm; id_use_rd = urd;
    id_rf_en = rf; id_load = ld; id_branch_taken = br;
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (obs1 !== 10'b1000_00_00_00) begin errors++; $display("FAIL reset_dut1 got %b exp %b", obs1, 10'b1000000000); end
    checks++; if (obs3 !== 10'b1000_00_00_00) begin errors++; $display("FAIL reset_dut3 got %b exp %b", obs3, 10'b1000000000); end
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    drive(4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    drive(4'd1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (obs1 !== 10'b1000_01_00_00) begin errors++; $display("FAIL b2b_ex got %b exp %b", obs1, 10'b1000010000); end
    @(posedge clk);
    drive(4'd1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (obs1 !== 10'b1000_10_00_00) begin errors++; $display("FAIL b2b_mem got %b exp %b", obs1, 10'b1000100000); end
    @(posedge clk);
    drive(4'd1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (obs1 !== 10'b1000_11_00_00) begin errors++; $display("FAIL b2b_wb got %b exp %b", obs1, 10'b1000110000); end
    @(posedge clk);
    drive(4'd1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (obs1 !== 10'b1000_00_00_00) begin errors++; $display("FAIL b2b_rf got %b exp %b", obs1, 10'b1000000000); end
    @(posedge clk);
    idle(2);
  endtask

  task automatic test_load_use();
    drive(4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    drive(4'd0, 4'd2, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (obs1 !== 10'b0100_00_01_00) begin errors++; $display("FAIL lu1_bubble got %b exp %b", obs1, 10'b0100000100); end
    checks++; if (obs3 !== 10'b0100_00_01_00) begin errors++; $display("FAIL lu3_bubble0 got %b exp %b", obs3, 10'b0100000100); end
    @(posedge clk);
    drive(4'd0, 4'd2, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (obs1 !== 10'b1000_00_10_00) begin errors++; $display("FAIL lu1_release got %b exp %b", obs1, 10'b1000001000); end
    checks++; if (obs3 !== 10'b0101_00_10_00) begin errors++; $display("FAIL lu3_stall1 got %b exp %b", obs3, 10'b0101001000); end
    @(posedge clk);
    drive(4'd0, 4'd2, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (obs3 !== 10'b0101_00_11_00) begin errors++; $display("FAIL lu3_stall2 got %b exp %b", obs3, 10'b0101001100); end
    @(posedge clk);
    drive(4'd0, 4'd2, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (obs3 !== 10'b1000_00_00_00) begin errors++; $display("FAIL lu3_release got %b exp %b", obs3, 10'b1000000000); end
    @(posedge clk);
    idle(3);
  endtask

  task automatic test_branch();
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (obs1 !== 10'b1010_00_00_00) begin errors++; $display("FAIL br_flush got %b exp %b", obs1, 10'b1010000000); end
    @(posedge clk);
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (obs1 !== 10'b1000_00_00_00) begin errors++; $display("FAIL br_flushstate got %b exp %b", obs1, 10'b1000000000); end
    @(posedge clk);
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (obs1 !== 10'b1010_00_00_00) begin errors++; $display("FAIL br_rehandle got %b exp %b", obs1, 10'b1010000000); end
    @(posedge clk);
    idle(2);
  endtask

  task automatic test_lu_branch();
    drive(4'd0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    drive(4'd4, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (obs1 !== 10'b0100_01_00_00) begin errors++; $display("FAIL lubr_bubble got %b exp %b", obs1, 10'b0100010000); end
    @(posedge clk);
    drive(4'd4, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (obs1 !== 10'b1010_10_00_00) begin errors++; $display("FAIL lubr_flush got %b exp %b", obs1, 10'b1010100000); end
    checks++; if (obs3 !== 10'b0101_10_00_00) begin errors++; $display("FAIL lubr3_stall got %b exp %b", obs3, 10'b0101100000); end
    @(posedge clk);
    idle(4);
  endtask

  task automatic test_r15_priority();
    drive(4'd0, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    drive(4'd15, 4'd15, 4'd15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (obs1 !== 10'b1000_00_00_00) begin errors++; $display("FAIL r15_dut1 got %b exp %b", obs1, 10'b1000000000); end
    checks++; if (obs3 !== 10'b1000_00_00_00) begin errors++; $display("FAIL r15_dut3 got %b exp %b", obs3, 10'b1000000000); end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
    end
    drive(4'd3, 4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (obs1 !== 10'b1000_01_01_01) begin errors++; $display("FAIL prio_ex got %b exp %b", obs1, 10'b1000010101); end
    @(posedge clk);
    drive(4'd3, 4'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (obs1 !== 10'b1000_00_10_00) begin errors++; $display("FAIL prio_use got %b exp %b", obs1, 10'b1000001000); end
    @(posedge clk);
    idle(3);
  endtask

  task automatic test_reset_mid_stall();
    drive(4'd0, 4'd0, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    drive(4'd6, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    drive(4'd6, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (obs3 !== 10'b0101_10_00_00) begin errors++; $display("FAIL rst_in_stall got %b exp %b", obs3, 10'b0101100000); end
    reset = 1'b1;
    @(posedge clk);
    drive(4'd6, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    checks++; if (obs3 !== 10'b1000_00_00_00) begin errors++; $display("FAIL rst_after_stall got %b exp %b", obs3, 10'b1000000000); end
    checks++; if (obs1 !== 10'b1000_00_00_00) begin errors++; $display("FAIL rst_after_dut1 got %b exp %b", obs1, 10'b1000000000); end
    @(posedge clk);
    idle(3);
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    do_reset();
    #1;
    checks++; if ({sc1, fc1, sc3, fc3} !== 64'd0) begin errors++; $display("FAIL stats_reset got %h exp 0", {sc1, fc1, sc3, fc3}); end
    for (int i = 0; i < 5; i++) begin
      drive(4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      @(posedge clk);
      drive(4'd7, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      idle(3);
    end
    for (int i = 0; i < 2; i++) begin
      drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      idle(1);
    end
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (sc1 !== 16'd5)  begin errors++; $display("FAIL stats_stall1 got %0d exp 5", sc1); end
    checks++; if (fc1 !== 16'd2)  begin errors++; $display("FAIL stats_flush1 got %0d exp 2", fc1); end
    checks++; if (sc3 !== 16'd15) begin errors++; $display("FAIL stats_stall3 got %0d exp 15", sc3); end
    checks++; if (fc3 !== 16'd2)  begin errors++; $display("FAIL stats_flush3 got %0d exp 2", fc3); end
    @(posedge clk);
  endtask
`endif

  function automatic logic [3:0] rnd_addr();
    int v;
    v = $urandom_range(0, 4);
    return (v == 4) ? 4'hF : 4'(v);
  endfunction

  task automatic test_random();
    logic [9:0] got;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) mp[k][s] = '0;
      bubbles_left[k] = 0;
      in_flush[k]     = 1'b0;
    end
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      reset           = ($urandom_range(0, 59) == 0);
      id_rn           = rnd_addr();
      id_rm           = rnd_addr();
      id_rd           = rnd_addr();
      id_use_rn       = 1'($urandom_range(0, 1));
      id_use_rm       = 1'($urandom_range(0, 1));
      id_use_rd       = ($urandom_range(0, 3) == 0);
      id_rf_en        = ($urandom_range(0, 4) < 3);
      id_load         = ($urandom_range(0, 2) == 0);
      id_branch_taken = ($urandom_range(0, 5) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        m_eval(k);
        got = (k == 0) ? obs1 : obs3;
        checks++;
        if (got !== exp_b[k]) begin
          errors++;
          $display("FAIL rand_dut%0d cyc=%0d got %b exp %b", (k == 0) ? 1 : 3, i, got, exp_b[k]);
        end
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) m_step(k);
    end
    @(negedge clk);
    reset = 1'b0;
    idle(4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    id_rn = 4'd0; id_rm = 4'd0; id_rd = 4'd0;
    id_use_rn = 1'b0; id_use_rm = 1'b0; id_use_rd = 1'b0;
    id_rf_en = 1'b0; id_load = 1'b0; id_branch_taken = 1'b0;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_branch();
    test_lu_branch();
    test_r15_priority();
    test_reset_mid_stall();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Pipeline controller for the 5-stage ARM PPU (IF, ID, EX, MEM, WB).
- Keeps a registered shadow of destination-register tags for the EX, MEM and WB stages.
- Detects load-use and branch hazards and drives the PC / IF-ID load enable (LE), the cuMux NOP select and the IF-ID flush.
- Produces operand forwarding selects for the three ID-stage register reads (Rn, Rm, Rd-as-store-data).

Parameters:
- LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard (1..3; 1 for the single-cycle data memory).
- REG_AW, 4, register address width (R0..R15).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state
- id_rn  in  REG_AW  Rn address of the instruction in ID
- id_rm  in  REG_AW  Rm address of the instruction in ID
- id_rd  in  REG_AW  Rd address (destination, or store-data source) in ID
- id_use_rn  in  1  ID instruction reads Rn
- id_use_rm  in  1  ID instruction reads Rm
- id_use_rd  in  1  ID instruction reads Rd (store)
- id_rf_en  in  1  ID instruction writes Rd (CU rf_en, pre-mux)
- id_load  in  1  ID instruction is a load (CU Load, pre-mux)
- id_branch_taken  in  1  branch in ID resolved taken this cycle
- le_out  out  1  PC and IF/ID load enable; 0 = hold
- nop_sel  out  1  cuMux select; 1 = force all control fields to zero (bubble)
- ifid_flush  out  1  clears IF/ID to the all-zero NOP on the next edge
- fwd_rn  out  2  Rn operand source: 00 RF, 01 EX, 10 MEM, 11 WB
- fwd_rm  out  2  Rm operand source, same encoding
- fwd_rd  out  2  store-data source, same encoding
- stall_active  out  1  FSM is in STALL

Behaviour:
- Tag pipeline, registered each edge:
  - EX tag <= {id_rd, id_rf_en & ~nop_sel, id_load & ~nop_sel}
  - MEM tag <= EX tag
  - WB tag <= MEM tag
  - On reset, all valid bits go to 0.
- Forwarding, combinational from the tags and ID addresses. For each operand:
  - Priority EX > MEM > WB.
  - A stage matches when its tag is valid, its address equals the operand address, and the operand's use bit is 1.
  - R15 (address 4'hF) is never forwarded; the select stays 00.
  - No match gives 00.
- Load-use hazard: EX tag valid, EX tag is a load, and its address matches any used ID operand (excluding R15).
- FSM states RUN, STALL, FLUSH. Reset enters RUN with counter 0.
  - RUN:
    - Load-use hazard: le_out=0, nop_sel=1, ifid_flush=0. Go to STALL with counter = LOAD_USE_STALLS-1, or go straight back to RUN when LOAD_USE_STALLS=1.
    - Else id_branch_taken: le_out=1, nop_sel=0, ifid_flush=1. Go to FLUSH.
    - Else: le_out=1, nop_sel=0, ifid_flush=0.
  - STALL: le_out=0, nop_sel=1. Decrement the counter; go to RUN when it reaches 0.
  - FLUSH: le_out=1, nop_sel=0, ifid_flush=0. Lasts one cycle, then RUN; a branch arriving in that cycle is re-handled from RUN the following cycle.
- Simultaneous load-use and branch_taken: the stall wins. The branch stays in ID and is resolved after the bubble.
- Bubbles enter the tag pipeline invalid, so an inserted NOP never forwards or stalls.
- Reset mid-stall or mid-flush: next cycle le_out=1, nop_sel=0, ifid_flush=0, fwd_*=00.
- Reset values: le_out=1, nop_sel=0, ifid_flush=0, fwd_*=00, stall_active=0.
- Latency: hazard outputs are combinational in the same cycle; tags and state update on the edge.

Optional Feature:
- HAZARD_STATS_EN defined:
  - Adds outputs stall_count[15:0] and flush_count[15:0].
  - stall_count increments per bubble cycle; flush_count increments per ifid_flush cycle.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Back-to-back ALU ops: ADD R1 (rf_en, rd=1), then ID reads rn=1 -> fwd_rn=01 that cycle; a third instruction reading R1 gets 10, a fourth gets 11, and a fifth gets 00.
- LDR R2 then use of R2 as rm -> exactly one cycle of le_out=0 and nop_sel=1, then fwd_rm=10 with le_out=1. Repeat with LOAD_USE_STALLS=3 -> three bubble cycles and stall_active=1 for 2 cycles.
- Taken branch in ID -> ifid_flush=1 for one cycle, FSM in FLUSH for one cycle, no bubble.
- Load-use and id_branch_taken asserted together -> bubble first with ifid_flush=0; branch flush the following cycle.
- Writer of R15, then reader of R15 -> fwd=00 and no stall even if the writer is a load; three writers to R3 in flight -> EX wins (01).
- reset asserted in STALL with counter=2 -> next cycle le_out=1, nop_sel=0, all tags invalid. With HAZARD_STATS_EN: counters read 0, and after 5 stalls and 2 flushes read 5 and 2.
